// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encodings, the register-index width, the default
// performance-counter width and a small operand-match helper.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned ST_W      = 2;

    localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
    localparam logic [ST_W-1:0] ST_DRAIN  = 2'd1;
    localparam logic [ST_W-1:0] ST_HALTED = 2'd2;

    // True when an enabled source operand names the given destination register.
    function automatic logic reads_reg(
        input logic             use_f,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dst
    );
        return use_f && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipe_hazard_ctrl.
// Pipeline -> controller: ID operand info, EX load/redirect info, MEM
// handshake, CP0 exception request, WB halt bit, resume pulse.
// Controller -> pipeline: PC/stage-register enables, stage clears, halted.
// master: pipeline side. slave: controller side.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_halt;
    logic             ex_r_datamem;
    logic [REG_W-1:0] ex_regfile_req_w;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ack;
    logic             exc_req;
    logic             wb_halt;
    logic             resume;

    logic             pc_en;
    logic             ps1_en;
    logic             ps2_en;
    logic             ps3_en;
    logic             ps4_en;
    logic             ps1_clear;
    logic             ps2_clear;
    logic             ps3_clear;
    logic             ps4_clear;
    logic             halted;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
               ex_r_datamem, ex_regfile_req_w, ex_redirect,
               mem_req, mem_ack, exc_req, wb_halt, resume,
        input  pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
               ps1_clear, ps2_clear, ps3_clear, ps4_clear, halted
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
               ex_r_datamem, ex_regfile_req_w, ex_redirect,
               mem_req, mem_ack, exc_req, wb_halt, resume,
        output pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
               ps1_clear, ps2_clear, ps3_clear, ps4_clear, halted
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts inc cycles, holds at all-ones.
// Ports: clk, rst (async, active-high), inc, value[W-1:0] (registered).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core.
// Ports: clk, rst (async, active-high); hz (pipe_hazard_ctrl_if.slave)
// carrying hazard inputs and the PC/stage enables, clears and halted;
// stall_cnt / flush_cnt saturating performance counters.
// Enables/clears are combinational from hz inputs and the RUN/DRAIN/HALTED
// state; priority is MEM wait > exception > redirect > load-use > halt.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;

    logic mem_wait;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    logic pc_en, ps1_en, ps2_en, ps3_en, ps4_en;
    logic ps1_clear, ps2_clear, ps3_clear, ps4_clear;
    logic halted;

    assign mem_wait = hz.mem_req && !hz.mem_ack;
    assign load_use = hz.ex_r_datamem && (hz.ex_regfile_req_w != '0) &&
                      (reads_reg(hz.id_use_rs, hz.id_rs, hz.ex_regfile_req_w) ||
                       reads_reg(hz.id_use_rt, hz.id_rt, hz.ex_regfile_req_w));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, enables, clears and counter strobes
    always_comb begin
        state_nxt = state;
        pc_en     = 1'b1;
        ps1_en    = 1'b1;
        ps2_en    = 1'b1;
        ps3_en    = 1'b1;
        ps4_en    = 1'b1;
        ps1_clear = 1'b0;
        ps2_clear = 1'b0;
        ps3_clear = 1'b0;
        ps4_clear = 1'b0;
        halted    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (rst) begin
            pc_en  = 1'b0;
            ps1_en = 1'b0;
            ps2_en = 1'b0;
            ps3_en = 1'b0;
            ps4_en = 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_wait) begin
                        // Freeze everything older than WB; WB takes a bubble
                        pc_en     = 1'b0;
                        ps1_en    = 1'b0;
                        ps2_en    = 1'b0;
                        ps3_en    = 1'b0;
                        ps4_clear = 1'b1;
                        stall_inc = 1'b1;
                    end else if (hz.exc_req) begin
                        // PC mux selects the exception vector, so PC keeps loading
                        ps1_clear = 1'b1;
                        ps2_clear = 1'b1;
                        ps3_clear = 1'b1;
                        flush_inc = 1'b1;
                    end else if (hz.ex_redirect) begin
                        // Redirect also squashes the load-use consumer: no stall
                        ps1_clear = 1'b1;
                        ps2_clear = 1'b1;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        // One bubble; the load leaves EX so it resolves next cycle
                        pc_en     = 1'b0;
                        ps1_en    = 1'b0;
                        ps2_clear = 1'b1;
                        stall_inc = 1'b1;
                    end else if (hz.id_halt) begin
                        state_nxt = ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // Stop fetching; feed bubbles behind the halt
                    pc_en     = 1'b0;
                    ps1_clear = 1'b1;
                    if (mem_wait) begin
                        ps1_en    = 1'b0;
                        ps2_en    = 1'b0;
                        ps3_en    = 1'b0;
                        ps4_clear = 1'b1;
                    end else if (hz.exc_req) begin
                        // Exception kills the younger halt; resume at the vector
                        pc_en     = 1'b1;
                        ps2_clear = 1'b1;
                        ps3_clear = 1'b1;
                        flush_inc = 1'b1;
                        state_nxt = ST_RUN;
                    end else if (hz.wb_halt) begin
                        state_nxt = ST_HALTED;
                    end
                end

                ST_HALTED: begin
                    pc_en  = 1'b0;
                    ps1_en = 1'b0;
                    ps2_en = 1'b0;
                    ps3_en = 1'b0;
                    ps4_en = 1'b0;
                    halted = 1'b1;
                    if (hz.resume) begin
                        // Flush the halt out of WB and restart fetch
                        pc_en     = 1'b1;
                        ps4_clear = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end

                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign hz.pc_en     = pc_en;
    assign hz.ps1_en    = ps1_en;
    assign hz.ps2_en    = ps2_en;
    assign hz.ps3_en    = ps3_en;
    assign hz.ps4_en    = ps4_en;
    assign hz.ps1_clear = ps1_clear;
    assign hz.ps2_clear = ps2_clear;
    assign hz.ps3_clear = ps3_clear;
    assign hz.ps4_clear = ps4_clear;
    assign hz.halted    = halted;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .value (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (32-bit and 4-bit
// counters) share one stimulus stream. A hand table, hand sequences and a
// randomized run are checked against constants and a rule-level model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_use_rs = 0, id_use_rt = 0, id_halt = 0, ex_ld = 0, ex_redirect = 0;
    logic mem_req = 0, mem_ack = 0, exc_req = 0, wb_halt = 0, resume = 0;

    pipe_hazard_ctrl_if hz32 ();
    pipe_hazard_ctrl_if hz4 ();

    logic [31:0] stall32, flush32;
    logic [3:0]  stall4, flush4;
    logic [9:0]  ctl32, ctl4;

    int n_vec = 0;
    int n_err = 0;

    // Model state: separate flags rather than an encoded state
    bit     m_drain = 0;
    bit     m_halt  = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    always #5 clk = ~clk;

    assign hz32.id_rs = id_rs;             assign hz4.id_rs = id_rs;
    assign hz32.id_rt = id_rt;             assign hz4.id_rt = id_rt;
    assign hz32.id_use_rs = id_use_rs;     assign hz4.id_use_rs = id_use_rs;
    assign hz32.id_use_rt = id_use_rt;     assign hz4.id_use_rt = id_use_rt;
    assign hz32.id_halt = id_halt;         assign hz4.id_halt = id_halt;
    assign hz32.ex_r_datamem = ex_ld;      assign hz4.ex_r_datamem = ex_ld;
    assign hz32.ex_regfile_req_w = ex_rd;  assign hz4.ex_regfile_req_w = ex_rd;
    assign hz32.ex_redirect = ex_redirect; assign hz4.ex_redirect = ex_redirect;
    assign hz32.mem_req = mem_req;         assign hz4.mem_req = mem_req;
    assign hz32.mem_ack = mem_ack;         assign hz4.mem_ack = mem_ack;
    assign hz32.exc_req = exc_req;         assign hz4.exc_req = exc_req;
    assign hz32.wb_halt = wb_halt;         assign hz4.wb_halt = wb_halt;
    assign hz32.resume = resume;           assign hz4.resume = resume;

    assign ctl32 = {hz32.pc_en, hz32.ps1_en, hz32.ps2_en, hz32.ps3_en, hz32.ps4_en,
                    hz32.ps1_clear, hz32.ps2_clear, hz32.ps3_clear, hz32.ps4_clear, hz32.halted};
    assign ctl4  = {hz4.pc_en, hz4.ps1_en, hz4.ps2_en, hz4.ps3_en, hz4.ps4_en,
                    hz4.ps1_clear, hz4.ps2_clear, hz4.ps3_clear, hz4.ps4_clear, hz4.halted};

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hz(hz32), .stall_cnt(stall32), .flush_cnt(flush32)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hz(hz4), .stall_cnt(stall4), .flush_cnt(flush4)
    );

    // Control vector order: {pc,ps1,ps2,ps3,ps4 en, ps1..ps4 clear, halted}
    localparam logic [9:0] C_ZERO     = 10'b00000_0000_0;
    localparam logic [9:0] C_NORM     = 10'b11111_0000_0;
    localparam logic [9:0] C_LU       = 10'b00111_0100_0;
    localparam logic [9:0] C_RED      = 10'b11111_1100_0;
    localparam logic [9:0] C_EXC      = 10'b11111_1110_0;
    localparam logic [9:0] C_MEMW     = 10'b00001_0001_0;
    localparam logic [9:0] C_DRAIN    = 10'b01111_1000_0;
    localparam logic [9:0] C_DRAIN_MW = 10'b00001_1001_0;
    localparam logic [9:0] C_HALT     = 10'b00000_0000_1;
    localparam logic [9:0] C_RESUME   = 10'b10000_0001_1;

    typedef struct {
        logic       mreq, mack, exc, red, ld;
        logic [4:0] rd;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic       hlt;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic mreq, mack, exc, red, ld, input logic [4:0] rd,
                                input logic urs, input logic [4:0] rs,
                                input logic urt, input logic [4:0] rt,
                                input logic hlt, input logic [9:0] exp);
        vec_t v;
        v.mreq = mreq; v.mack = mack; v.exc = exc; v.red = red; v.ld = ld; v.rd = rd;
        v.urs = urs; v.rs = rs; v.urt = urt; v.rt = rt; v.hlt = hlt; v.exp = exp;
        return v;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Rule-level model: returns expected controls plus counter/state effects
    task automatic model_eval(output logic [9:0] ctl, output bit st, output bit fl,
                              output bit nd, output bit nh);
        bit run    = !m_drain && !m_halt;
        bit freeze = mem_req && !mem_ack && !m_halt;
        bit hzd    = ex_ld && (ex_rd != 5'd0) &&
                     ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        bit exc_fl = !freeze && exc_req && !m_halt;
        bit red_fl = run && !freeze && !exc_req && ex_redirect;
        bit lu     = run && !freeze && !exc_req && !ex_redirect && hzd;
        bit res    = m_halt && resume;
        bit pc, p1, p2, p3, p4;
        if (run)          pc = !(freeze || lu);
        else if (m_drain) pc = exc_fl;
        else              pc = res;
        p1 = !m_halt && !(freeze || lu);
        p2 = !m_halt && !freeze;
        p3 = !m_halt && !freeze;
        p4 = !m_halt;
        ctl = {pc, p1, p2, p3, p4, m_drain || exc_fl || red_fl, exc_fl || red_fl || lu,
               exc_fl, freeze || res, m_halt};
        st = run && !pc;
        fl = exc_fl || red_fl;
        nd = m_drain;
        nh = m_halt;
        if (run && !freeze && !exc_req && !ex_redirect && !hzd && id_halt) nd = 1;
        if (m_drain && exc_fl) nd = 0;
        else if (m_drain && !freeze && wb_halt) begin nd = 0; nh = 1; end
        if (res) nh = 0;
    endtask

    task automatic model_step();
        logic [9:0] c;
        bit st, fl, nd, nh;
        model_eval(c, st, fl, nd, nh);
        if (st) m_stall++;
        if (fl) m_flush++;
        m_drain = nd;
        m_halt  = nh;
    endtask

    task automatic model_reset();
        m_drain = 0; m_halt = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_cnts(input string nm);
        check({nm, "/stall32"}, stall32, 32'(sat(m_stall, 32)));
        check({nm, "/flush32"}, flush32, 32'(sat(m_flush, 32)));
        check({nm, "/stall4"}, {28'd0, stall4}, 32'(sat(m_stall, 4)));
        check({nm, "/flush4"}, {28'd0, flush4}, 32'(sat(m_flush, 4)));
    endtask

    // Entered just after a posedge with inputs set; checks controls mid-cycle
    task automatic cycle(input logic [9:0] exp, input string nm);
        @(negedge clk);
        check({nm, "/ctl32"}, {22'd0, ctl32}, {22'd0, exp});
        check({nm, "/ctl4"}, {22'd0, ctl4}, {22'd0, exp});
        @(posedge clk);
        model_step();
        #1;
        check_cnts(nm);
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rs = 0; id_use_rt = 0; id_halt = 0;
        ex_ld = 0; ex_redirect = 0; mem_req = 0; mem_ack = 0; exc_req = 0;
        wb_halt = 0; resume = 0;
    endtask

    // Asynchronous reset pulse between edges
    task automatic pulse_reset(input string nm);
        rst = 1'b1;
        #2;
        model_reset();
        check({nm, "/ctl_in_rst"}, {22'd0, ctl32}, {22'd0, C_ZERO});
        check_cnts({nm, "/rst"});
        rst = 1'b0;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [9:0] exp;
        bit st, fl, nd, nh;

        idle();
        // Power-on reset
        #12;
        check("por/ctl", {22'd0, ctl32}, {22'd0, C_ZERO});
        check_cnts("por");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step();
        #1;

        // Single-cycle RUN-state priority table
        tbl[0]  = mk(0,0,0,0,0, 5'd0, 0,5'd0, 0,5'd0, 0, C_NORM);
        tbl[1]  = mk(0,0,0,0,1, 5'd5, 1,5'd5, 0,5'd0, 0, C_LU);
        tbl[2]  = mk(0,0,0,0,1, 5'd0, 1,5'd0, 0,5'd0, 0, C_NORM);
        tbl[3]  = mk(0,0,0,0,1, 5'd5, 0,5'd1, 1,5'd5, 0, C_LU);
        tbl[4]  = mk(0,0,0,0,1, 5'd5, 0,5'd5, 0,5'd5, 0, C_NORM);
        tbl[5]  = mk(0,0,0,1,1, 5'd5, 1,5'd5, 0,5'd0, 0, C_RED);
        tbl[6]  = mk(0,0,1,0,0, 5'd0, 0,5'd0, 0,5'd0, 0, C_EXC);
        tbl[7]  = mk(1,0,1,0,0, 5'd0, 0,5'd0, 0,5'd0, 0, C_MEMW);
        tbl[8]  = mk(1,1,0,0,0, 5'd0, 0,5'd0, 0,5'd0, 0, C_NORM);
        tbl[9]  = mk(0,0,0,0,1, 5'd6, 1,5'd5, 1,5'd7, 0, C_NORM);
        tbl[10] = mk(0,0,1,1,0, 5'd0, 0,5'd0, 0,5'd0, 0, C_EXC);
        tbl[11] = mk(0,0,0,0,1, 5'd9, 1,5'd9, 0,5'd0, 1, C_LU);
        tbl[12] = mk(1,0,0,0,0, 5'd0, 0,5'd0, 0,5'd0, 1, C_MEMW);
        for (int i = 0; i < 13; i++) begin
            mem_req = tbl[i].mreq; mem_ack = tbl[i].mack; exc_req = tbl[i].exc;
            ex_redirect = tbl[i].red; ex_ld = tbl[i].ld; ex_rd = tbl[i].rd;
            id_use_rs = tbl[i].urs; id_rs = tbl[i].rs; id_use_rt = tbl[i].urt;
            id_rt = tbl[i].rt; id_halt = tbl[i].hlt;
            cycle(tbl[i].exp, $sformatf("tbl%0d", i));
        end
        idle();
        check("tbl/stall_total", stall32, 32'd5);
        check("tbl/flush_total", flush32, 32'd3);

        // Three-cycle data-memory wait
        pulse_reset("rstA");
        mem_req = 1;
        for (int i = 0; i < 3; i++) cycle(C_MEMW, "memwait");
        mem_ack = 1;
        cycle(C_NORM, "memack");
        idle();
        check("memwait/stall", stall32, 32'd3);

        // Halt drain, halted, resume
        id_halt = 1;
        cycle(C_NORM, "halt_entry");
        id_halt = 0; mem_req = 1;
        cycle(C_DRAIN_MW, "drain_memwait");
        mem_req = 0;
        cycle(C_DRAIN, "drain1");
        cycle(C_DRAIN, "drain2");
        wb_halt = 1;
        cycle(C_DRAIN, "drain_wbhalt");
        cycle(C_HALT, "halted1");
        wb_halt = 0;
        cycle(C_HALT, "halted2");
        resume = 1;
        cycle(C_RESUME, "resume");
        resume = 0;
        cycle(C_NORM, "after_resume");
        resume = 1;
        cycle(C_NORM, "resume_in_run");
        resume = 0;
        check("halt/stall", stall32, 32'd3);

        // Exception during drain returns to RUN
        id_halt = 1;
        cycle(C_NORM, "halt_entry2");
        id_halt = 0;
        cycle(C_DRAIN, "drain_b");
        exc_req = 1; wb_halt = 1;
        cycle(C_EXC, "drain_exc");
        exc_req = 0; wb_halt = 0;
        cycle(C_NORM, "post_exc");
        check("drain_exc/flush", flush32, 32'd1);

        // Counter saturation, then reset from DRAIN
        pulse_reset("rstB");
        mem_req = 1;
        for (int i = 0; i < 20; i++) cycle(C_MEMW, "sat");
        mem_req = 0;
        check("sat/stall32", stall32, 32'd20);
        check("sat/stall4", {28'd0, stall4}, 32'd15);
        id_halt = 1;
        cycle(C_NORM, "halt_entry3");
        id_halt = 0;
        cycle(C_DRAIN, "drain_c");
        pulse_reset("rst_in_drain");
        cycle(C_NORM, "run_after_rst");

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            mem_req     = ($urandom_range(0, 99) < 30);
            mem_ack     = $urandom_range(0, 1);
            exc_req     = ($urandom_range(0, 99) < 5);
            ex_redirect = ($urandom_range(0, 99) < 10);
            ex_ld       = ($urandom_range(0, 99) < 40);
            ex_rd       = 5'($urandom_range(0, 7));
            id_rs       = 5'($urandom_range(0, 7));
            id_rt       = 5'($urandom_range(0, 7));
            id_use_rs   = $urandom_range(0, 1);
            id_use_rt   = $urandom_range(0, 1);
            id_halt     = ($urandom_range(0, 99) < 6);
            wb_halt     = ($urandom_range(0, 99) < 20);
            resume      = ($urandom_range(0, 99) < 15);
            model_eval(exp, st, fl, nd, nh);
            cycle(exp, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage core.
- Drives the en/clear pins of the four pipeline-stage registers (PS1 IF/ID, PS2 ID/EX, PS3 EX/MEM, PS4 MEM/WB) and the PC enable.
- Resolves, by fixed priority: load-use hazards, branch/jump redirects, CP0 exception flushes, multi-cycle data-memory waits, and the halt drain/resume sequence.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt counters.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_halt  in  1  ID instruction is halt
ex_r_datamem  in  1  EX instruction is a load
ex_regfile_req_w  in  5  EX destination register
ex_redirect  in  1  EX branch taken or jump
mem_req  in  1  MEM stage is accessing data memory
mem_ack  in  1  data memory completes the access this cycle
exc_req  in  1  CP0 exception/interrupt/eret taken in MEM
wb_halt  in  1  halt bit at the PS4 output
resume  in  1  restart after halt (pulse)
pc_en, ps1_en, ps2_en, ps3_en, ps4_en  out  1 each  stage-register/PC load enables
ps1_clear, ps2_clear, ps3_clear, ps4_clear  out  1 each  stage-register synchronous clears
halted  out  1  core is halted
stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN
flush_cnt  out  CNT_W  redirect/exception flush events

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset: state=RUN, both counters 0.
- While rst is high, all en=0 and all clear=0.
- Enables and clears are combinational from inputs and state. Defaults: every en=1, every clear=0.
- Priority in RUN, highest first:
  - MEM wait (mem_req & !mem_ack): pc_en=ps1_en=ps2_en=ps3_en=0, ps4_clear=1 (bubble into WB).
  - exc_req: ps1_clear=ps2_clear=ps3_clear=1, pc_en=1 (the PC mux selects the vector); flush_cnt+1.
  - ex_redirect: ps1_clear=ps2_clear=1; flush_cnt+1.
  - load-use hazard: ex_r_datamem & ex_regfile_req_w!=0 & ((id_use_rs & id_rs==ex_regfile_req_w) | (id_use_rt & id_rt==ex_regfile_req_w)). Response: pc_en=ps1_en=0, ps2_clear=1. Lasts exactly one cycle per occurrence.
- Redirect and load-use in the same cycle: redirect wins; no stall is inserted.
- Halt in ID, when no higher-priority event and no load-use hazard: go to DRAIN next cycle. In the entry cycle the halt advances into PS2 normally.
- DRAIN:
  - pc_en=0, ps1_clear=1 every cycle. MEM wait still freezes stages as in RUN.
  - exc_req: apply the exception flush (this kills the younger halt) and return to RUN.
  - wb_halt=1: go to HALTED.
- HALTED: all en=0, all clear=0, halted=1. Register contents are preserved.
  - resume: go to RUN; in that transition cycle ps4_clear=1 and pc_en=1, so the halt bit leaves WB.
  - resume while not HALTED: ignored.
- stall_cnt increments each RUN cycle with pc_en=0. flush_cnt increments per flush cycle. Both saturate at all-ones and never wrap.
- Reset asserted mid-DRAIN or mid-HALTED: immediate return to RUN; counters go to 0.

Decomposition:
- Shared core header gets the state encodings (ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2) and the CNT_W default.
- One sub-module: sat_counter (width parameter, inc, synchronous value output with asynchronous active-high reset). It is instantiated twice.

Test Plan:
- Load to r5 in EX, ID reads r5 via rs → one cycle of pc_en=0, ps1_en=0, ps2_clear=1; stall_cnt goes 0→1. The same case with a load to r0 → no stall.
- ex_redirect and the load-use condition in the same cycle → ps1_clear=ps2_clear=1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
- mem_req=1 with mem_ack low for 3 cycles → pc/ps1–ps3 en=0 and ps4_clear=1 for exactly 3 cycles; stall_cnt=3. On the ack cycle all en=1.
- id_halt=1 → DRAIN with ps1_clear=1. 3 cycles later wb_halt=1 → halted=1, all en=0. Pulse resume → one cycle with ps4_clear=1, then RUN.
- In DRAIN assert exc_req → ps1–ps3 clear, state RUN, flush_cnt+1. Halted never asserts.
- Set CNT_W=4 and force 20 stall cycles → stall_cnt holds at 15. Then pulse rst → counters 0, state RUN.
